// File: rtl/axi_cmd_arb.sv
// Round-robin command arbiter feeding the axi master's write and read ports.
// Each channel: one held command, a rotating priority pointer and a credit count.
module axi_cmd_arb_ch #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WD         = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_WD           = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
   input  logic [NUM_REQ*ADDR_WD-1:0] req_len,
   input  logic [NUM_REQ*2-1:0]       req_burst,
   input  logic [NUM_REQ*3-1:0]       req_size,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [ADDR_WD-1:0]         cmd_addr,
   output logic [ADDR_WD-1:0]         cmd_len,
   output logic [1:0]                 cmd_burst,
   output logic [2:0]                 cmd_size,
   output logic [ID_WD-1:0]           cmd_id,
   input  logic                       done,
   output logic [3:0]                 outstanding
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state, state_nxt;
   logic [ID_WD-1:0] rr_ptr, grant, ptr_nxt;
   logic [ID_WD:0]   scan;
   logic             found, accept, hs;

   always_comb begin
      grant = '0;
      found = 1'b0;
      scan  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (ID_WD+1)'(k);
         if (scan >= (ID_WD+1)'(NUM_REQ))
            scan = scan - (ID_WD+1)'(NUM_REQ);
         if (!found && req_valid[scan[ID_WD-1:0]]) begin
            grant = scan[ID_WD-1:0];
            found = 1'b1;
         end
      end
   end

   assign accept = !reset && (state == IDLE) && found &&
                   (outstanding < 4'(MAX_OUTSTANDING));
   assign hs        = (state == HOLD) && cmd_ready;
   assign cmd_valid = (state == HOLD);
   assign ptr_nxt   = (cmd_id == ID_WD'(NUM_REQ-1)) ? '0 : cmd_id + 1'b1;

   always_comb begin
      req_ready = '0;
      if (accept)
         req_ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = HOLD;
         HOLD: if (hs)     state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= '0;
         outstanding <= '0;
         cmd_addr    <= '0;
         cmd_len     <= '0;
         cmd_burst   <= '0;
         cmd_size    <= '0;
         cmd_id      <= '0;
      end else begin
         if (accept) begin
            cmd_addr  <= req_addr[int'(grant)*ADDR_WD +: ADDR_WD];
            cmd_len   <= req_len[int'(grant)*ADDR_WD +: ADDR_WD];
            cmd_burst <= req_burst[int'(grant)*2 +: 2];
            cmd_size  <= req_size[int'(grant)*3 +: 3];
            cmd_id    <= grant;
         end
         if (hs)
            rr_ptr <= ptr_nxt;
         // a done with no credit in use is a stray pulse and is dropped
         case ({hs, done})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

module axi_cmd_arb #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WD         = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_WD           = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_w_cmd_valid,
   output logic [NUM_REQ-1:0]         req_w_cmd_ready,
   input  logic [NUM_REQ*ADDR_WD-1:0] req_w_cmd_addr,
   input  logic [NUM_REQ*ADDR_WD-1:0] req_w_cmd_len,
   input  logic [NUM_REQ*2-1:0]       req_w_cmd_burst,
   input  logic [NUM_REQ*3-1:0]       req_w_cmd_size,
   input  logic [NUM_REQ-1:0]         req_r_cmd_valid,
   output logic [NUM_REQ-1:0]         req_r_cmd_ready,
   input  logic [NUM_REQ*ADDR_WD-1:0] req_r_cmd_addr,
   input  logic [NUM_REQ*ADDR_WD-1:0] req_r_cmd_len,
   input  logic [NUM_REQ*2-1:0]       req_r_cmd_burst,
   input  logic [NUM_REQ*3-1:0]       req_r_cmd_size,
   output logic                       w_cmd_valid,
   input  logic                       w_cmd_ready,
   output logic [ADDR_WD-1:0]         w_cmd_addr,
   output logic [ADDR_WD-1:0]         w_cmd_len,
   output logic [1:0]                 w_cmd_burst,
   output logic [2:0]                 w_cmd_size,
   output logic [ID_WD-1:0]           w_cmd_id,
   input  logic                       w_done,
   output logic [3:0]                 w_outstanding,
   output logic                       r_cmd_valid,
   input  logic                       r_cmd_ready,
   output logic [ADDR_WD-1:0]         r_cmd_addr,
   output logic [ADDR_WD-1:0]         r_cmd_len,
   output logic [1:0]                 r_cmd_burst,
   output logic [2:0]                 r_cmd_size,
   output logic [ID_WD-1:0]           r_cmd_id,
   input  logic                       r_done,
   output logic [3:0]                 r_outstanding
);

   axi_cmd_arb_ch #(
      .NUM_REQ(NUM_REQ), .ADDR_WD(ADDR_WD),
      .MAX_OUTSTANDING(MAX_OUTSTANDING), .ID_WD(ID_WD)
   ) u_w (
      .clk(clk), .reset(reset),
      .req_valid(req_w_cmd_valid), .req_ready(req_w_cmd_ready),
      .req_addr(req_w_cmd_addr), .req_len(req_w_cmd_len),
      .req_burst(req_w_cmd_burst), .req_size(req_w_cmd_size),
      .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
      .cmd_addr(w_cmd_addr), .cmd_len(w_cmd_len),
      .cmd_burst(w_cmd_burst), .cmd_size(w_cmd_size),
      .cmd_id(w_cmd_id), .done(w_done), .outstanding(w_outstanding)
   );

   axi_cmd_arb_ch #(
      .NUM_REQ(NUM_REQ), .ADDR_WD(ADDR_WD),
      .MAX_OUTSTANDING(MAX_OUTSTANDING), .ID_WD(ID_WD)
   ) u_r (
      .clk(clk), .reset(reset),
      .req_valid(req_r_cmd_valid), .req_ready(req_r_cmd_ready),
      .req_addr(req_r_cmd_addr), .req_len(req_r_cmd_len),
      .req_burst(req_r_cmd_burst), .req_size(req_r_cmd_size),
      .cmd_valid(r_cmd_valid), .cmd_ready(r_cmd_ready),
      .cmd_addr(r_cmd_addr), .cmd_len(r_cmd_len),
      .cmd_burst(r_cmd_burst), .cmd_size(r_cmd_size),
      .cmd_id(r_cmd_id), .done(r_done), .outstanding(r_outstanding)
   );

endmodule

// File: tb/tb_axi_cmd_arb.sv
// Bench for axi_cmd_arb: per-cycle reference model compare plus directed
// scenarios with literal expectations.
module tb_axi_cmd_arb;
   localparam int NR = 4, AW = 32, MAXO = 4, IW = 2;

   logic clk = 1'b0, reset = 1'b1;
   logic [NR-1:0] req_w_cmd_valid = '0, req_w_cmd_ready;
   logic [NR*AW-1:0] req_w_cmd_addr = '0, req_w_cmd_len = '0;
   logic [NR*2-1:0] req_w_cmd_burst = '0;
   logic [NR*3-1:0] req_w_cmd_size = '0;
   logic [NR-1:0] req_r_cmd_valid = '0, req_r_cmd_ready;
   logic [NR*AW-1:0] req_r_cmd_addr = '0, req_r_cmd_len = '0;
   logic [NR*2-1:0] req_r_cmd_burst = '0;
   logic [NR*3-1:0] req_r_cmd_size = '0;
   logic w_cmd_valid, r_cmd_valid;
   logic w_cmd_ready = 1'b0, r_cmd_ready = 1'b0;
   logic [AW-1:0] w_cmd_addr, w_cmd_len, r_cmd_addr, r_cmd_len;
   logic [1:0] w_cmd_burst, r_cmd_burst;
   logic [2:0] w_cmd_size, r_cmd_size;
   logic [IW-1:0] w_cmd_id, r_cmd_id;
   logic w_done, r_done = 1'b0, w_done_man = 1'b0;
   logic [3:0] w_outstanding, r_outstanding;

   logic [1:0] hs_d = '0;
   logic auto_done = 1'b0;
   assign w_done = w_done_man | hs_d[1];

   int checks = 0, failures = 0;
   bit mon_en = 0;
   int w_ids[$];
   logic [AW-1:0] w_addrs[$];
   int w_hs_cnt = 0;

   axi_cmd_arb #(.NUM_REQ(NR), .ADDR_WD(AW), .MAX_OUTSTANDING(MAXO), .ID_WD(IW)) dut (
      .clk(clk), .reset(reset),
      .req_w_cmd_valid(req_w_cmd_valid), .req_w_cmd_ready(req_w_cmd_ready),
      .req_w_cmd_addr(req_w_cmd_addr), .req_w_cmd_len(req_w_cmd_len),
      .req_w_cmd_burst(req_w_cmd_burst), .req_w_cmd_size(req_w_cmd_size),
      .req_r_cmd_valid(req_r_cmd_valid), .req_r_cmd_ready(req_r_cmd_ready),
      .req_r_cmd_addr(req_r_cmd_addr), .req_r_cmd_len(req_r_cmd_len),
      .req_r_cmd_burst(req_r_cmd_burst), .req_r_cmd_size(req_r_cmd_size),
      .w_cmd_valid(w_cmd_valid), .w_cmd_ready(w_cmd_ready),
      .w_cmd_addr(w_cmd_addr), .w_cmd_len(w_cmd_len),
      .w_cmd_burst(w_cmd_burst), .w_cmd_size(w_cmd_size),
      .w_cmd_id(w_cmd_id), .w_done(w_done), .w_outstanding(w_outstanding),
      .r_cmd_valid(r_cmd_valid), .r_cmd_ready(r_cmd_ready),
      .r_cmd_addr(r_cmd_addr), .r_cmd_len(r_cmd_len),
      .r_cmd_burst(r_cmd_burst), .r_cmd_size(r_cmd_size),
      .r_cmd_id(r_cmd_id), .r_done(r_done), .r_outstanding(r_outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: one pending command slot, pointer and credit per channel
   bit m_hold[2];
   int m_id[2], m_ptr[2], m_cnt[2];
   logic [AW-1:0] m_addr[2], m_len[2];
   logic [1:0] m_burst[2];
   logic [2:0] m_size[2];

   function automatic int exp_grant(int c);
      logic [NR-1:0] v;
      v = (c == 0) ? req_w_cmd_valid : req_r_cmd_valid;
      if (reset || m_hold[c] || m_cnt[c] >= MAXO) return -1;
      for (int k = 0; k < NR; k++)
         if (v[(m_ptr[c] + k) % NR]) return (m_ptr[c] + k) % NR;
      return -1;
   endfunction

   always @(posedge clk) begin
      int g;
      bit hs, dn;
      for (int c = 0; c < 2; c++) begin
         if (reset) begin
            m_hold[c] = 0; m_id[c] = 0; m_ptr[c] = 0; m_cnt[c] = 0;
         end else begin
            g  = exp_grant(c);
            hs = m_hold[c] && ((c == 0) ? w_cmd_ready : r_cmd_ready);
            dn = (c == 0) ? w_done : r_done;
            if (hs) begin
               m_hold[c] = 0;
               m_ptr[c] = (m_id[c] + 1) % NR;
            end
            if (hs && !dn) m_cnt[c]++;
            else if (!hs && dn && m_cnt[c] > 0) m_cnt[c]--;
            if (g >= 0) begin
               m_hold[c] = 1;
               m_id[c] = g;
               m_addr[c]  = (c == 0) ? req_w_cmd_addr[g*AW +: AW] : req_r_cmd_addr[g*AW +: AW];
               m_len[c]   = (c == 0) ? req_w_cmd_len[g*AW +: AW] : req_r_cmd_len[g*AW +: AW];
               m_burst[c] = (c == 0) ? req_w_cmd_burst[g*2 +: 2] : req_r_cmd_burst[g*2 +: 2];
               m_size[c]  = (c == 0) ? req_w_cmd_size[g*3 +: 3] : req_r_cmd_size[g*3 +: 3];
            end
         end
      end
   end

   always @(negedge clk) begin
      hs_d <= {hs_d[0], auto_done & w_cmd_valid & w_cmd_ready};
      if (mon_en) begin
         for (int c = 0; c < 2; c++) begin
            int g;
            logic [NR-1:0] er;
            g = exp_grant(c);
            er = (g >= 0) ? NR'(1 << g) : '0;
            chk($sformatf("ch%0d.req_ready", c), (c == 0) ? req_w_cmd_ready : req_r_cmd_ready, er);
            chk($sformatf("ch%0d.valid", c), (c == 0) ? w_cmd_valid : r_cmd_valid, m_hold[c]);
            chk($sformatf("ch%0d.outstanding", c), (c == 0) ? w_outstanding : r_outstanding, m_cnt[c]);
            if (m_hold[c]) begin
               chk($sformatf("ch%0d.addr", c), (c == 0) ? w_cmd_addr : r_cmd_addr, m_addr[c]);
               chk($sformatf("ch%0d.len", c), (c == 0) ? w_cmd_len : r_cmd_len, m_len[c]);
               chk($sformatf("ch%0d.burst", c), (c == 0) ? w_cmd_burst : r_cmd_burst, m_burst[c]);
               chk($sformatf("ch%0d.size", c), (c == 0) ? w_cmd_size : r_cmd_size, m_size[c]);
               chk($sformatf("ch%0d.id", c), (c == 0) ? w_cmd_id : r_cmd_id, m_id[c]);
            end
         end
         if (w_cmd_valid && w_cmd_ready) begin
            w_ids.push_back(int'(w_cmd_id));
            w_addrs.push_back(w_cmd_addr);
            w_hs_cnt++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int i, input logic v, input logic [AW-1:0] a,
                        input logic [AW-1:0] l, input logic [1:0] b, input logic [2:0] s);
      req_w_cmd_valid[i] = v;
      req_w_cmd_addr[i*AW +: AW] = a;
      req_w_cmd_len[i*AW +: AW] = l;
      req_w_cmd_burst[i*2 +: 2] = b;
      req_w_cmd_size[i*3 +: 3] = s;
   endtask

   task automatic do_reset;
      req_w_cmd_valid = '0;
      req_r_cmd_valid = '0;
      reset = 1'b1;
      tick;
      mon_en = 1;
      tick;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // single write and reset state
      do_reset;
      chk("rst.valid", w_cmd_valid, 1'b0);
      chk("rst.id", w_cmd_id, 2'd0);
      chk("rst.addr", w_cmd_addr, 32'h0);
      chk("rst.outst", w_outstanding, 4'd0);
      chk("rst.r_valid", r_cmd_valid, 1'b0);
      set_w(0, 1'b1, 32'h0, 32'h400, 2'b01, 3'd2);
      w_cmd_ready = 1'b1;
      #1 chk("t1.ready_N", req_w_cmd_ready, 4'b0001);
      tick;
      req_w_cmd_valid[0] = 1'b0;
      #1;
      chk("t1.valid_N1", w_cmd_valid, 1'b1);
      chk("t1.addr", w_cmd_addr, 32'h0);
      chk("t1.len", w_cmd_len, 32'h400);
      chk("t1.id", w_cmd_id, 2'd0);
      chk("t1.ready_hold", req_w_cmd_ready, 4'b0000);
      tick;
      chk("t1.outst_N2", w_outstanding, 4'd1);
      w_done_man = 1'b1;
      tick;
      w_done_man = 1'b0;
      #1 chk("t1.outst_done", w_outstanding, 4'd0);

      // rotation with all requesters valid, done returned after each handshake
      do_reset;
      w_ids.delete();
      w_addrs.delete();
      auto_done = 1'b1;
      for (int i = 0; i < NR; i++) set_w(i, 1'b1, 32'(i * 32'h400), 32'h40, 2'b01, 3'd2);
      repeat (17) tick;
      req_w_cmd_valid = '0;
      repeat (3) tick;
      auto_done = 1'b0;
      repeat (3) tick;
      chk("rot.count_ge8", 64'(w_ids.size() >= 8), 64'd1);
      if (w_ids.size() >= 8) begin
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("rot.id%0d", k), w_ids[k], k % 4);
            chk($sformatf("rot.addr%0d", k), w_addrs[k], 32'((k % 4) * 32'h400));
         end
      end

      // backpressure
      do_reset;
      w_hs_cnt = 0;
      w_ids.delete();
      w_cmd_ready = 1'b0;
      set_w(1, 1'b1, 32'h400, 32'h80, 2'b01, 3'd3);
      #1 chk("bp.accept", req_w_cmd_ready, 4'b0010);
      tick;
      req_w_cmd_valid[1] = 1'b0;
      repeat (5) begin
         #1;
         chk("bp.valid", w_cmd_valid, 1'b1);
         chk("bp.addr", w_cmd_addr, 32'h400);
         chk("bp.noready", req_w_cmd_ready, 4'b0000);
         tick;
      end
      w_cmd_ready = 1'b1;
      tick;
      tick;
      chk("bp.hs_once", w_hs_cnt, 1);
      chk("bp.valid_off", w_cmd_valid, 1'b0);
      if (w_ids.size() > 0) chk("bp.id", w_ids[0], 1);

      // credit exhaustion
      do_reset;
      w_hs_cnt = 0;
      for (int i = 0; i < NR; i++) set_w(i, 1'b1, 32'(32'h1000 + i), 32'h10, 2'b00, 3'd1);
      repeat (12) tick;
      #1;
      chk("cr.outst_max", w_outstanding, 4'd4);
      chk("cr.hs4", w_hs_cnt, 4);
      chk("cr.noready", req_w_cmd_ready, 4'b0000);
      w_done_man = 1'b1;
      tick;
      w_done_man = 1'b0;
      repeat (6) tick;
      #1;
      chk("cr.hs5", w_hs_cnt, 5);
      chk("cr.outst_refill", w_outstanding, 4'd4);
      req_w_cmd_valid = '0;

      // simultaneous done and handshake; done at zero; concurrent channels
      do_reset;
      w_cmd_ready = 1'b1;
      r_cmd_ready = 1'b1;
      set_w(0, 1'b1, 32'h100, 32'h0, 2'b01, 3'd2);
      tick;
      tick;
      tick;
      req_w_cmd_valid[0] = 1'b0;
      w_done_man = 1'b1;
      tick;
      w_done_man = 1'b0;
      #1 chk("sim.hs_done", w_outstanding, 4'd1);
      w_done_man = 1'b1;
      r_done = 1'b1;
      tick;
      tick;
      w_done_man = 1'b0;
      r_done = 1'b0;
      #1;
      chk("sim.w_zero", w_outstanding, 4'd0);
      chk("sim.r_zero", r_outstanding, 4'd0);
      set_w(2, 1'b1, 32'h2000, 32'h20, 2'b01, 3'd2);
      req_r_cmd_valid[3] = 1'b1;
      req_r_cmd_addr[3*AW +: AW] = 32'h3000;
      req_r_cmd_len[3*AW +: AW] = 32'h30;
      #1;
      chk("dual.w_ready", req_w_cmd_ready, 4'b0100);
      chk("dual.r_ready", req_r_cmd_ready, 4'b1000);
      tick;
      req_w_cmd_valid = '0;
      req_r_cmd_valid = '0;
      #1;
      chk("dual.w_id", w_cmd_id, 2'd2);
      chk("dual.r_id", r_cmd_id, 2'd3);
      chk("dual.r_addr", r_cmd_addr, 32'h3000);
      repeat (2) tick;

      // reset while holding a command
      do_reset;
      w_cmd_ready = 1'b1;
      set_w(1, 1'b1, 32'h500, 32'h8, 2'b01, 3'd2);
      tick;
      req_w_cmd_valid[1] = 1'b0;
      tick;
      w_cmd_ready = 1'b0;
      set_w(2, 1'b1, 32'h600, 32'h8, 2'b01, 3'd2);
      tick;
      req_w_cmd_valid[2] = 1'b0;
      #1;
      chk("rh.valid", w_cmd_valid, 1'b1);
      chk("rh.id", w_cmd_id, 2'd2);
      tick;
      reset = 1'b1;
      tick;
      #1;
      chk("rh.valid0", w_cmd_valid, 1'b0);
      chk("rh.id0", w_cmd_id, 2'd0);
      chk("rh.outst0", w_outstanding, 4'd0);
      reset = 1'b0;
      w_cmd_ready = 1'b1;
      for (int i = 0; i < NR; i++) set_w(i, 1'b1, 32'(32'h700 + i), 32'h8, 2'b01, 3'd2);
      #1 chk("rh.grant0", req_w_cmd_ready, 4'b0001);
      tick;
      req_w_cmd_valid = '0;
      repeat (3) tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
